// File: rtl/curr_block_loader_if.sv
// Beat-in / beat-out bundle between the upstream loader, the search controller and the PE array.
// The master drives beats and search_done. The slave (the loader) drives everything else.
interface curr_block_loader_if;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_ready;
    logic         search_done;
    logic         begin_prepare;
    logic         cur_valid;
    logic [511:0] current_64pixels;
    logic [1:0]   bank_full;

    modport master (
        output in_valid, in_data, search_done,
        input  in_ready, begin_prepare, cur_valid, current_64pixels, bank_full
    );

    modport slave (
        input  in_valid, in_data, search_done,
        output in_ready, begin_prepare, cur_valid, current_64pixels, bank_full
    );
endinterface

// File: rtl/curr_block_loader.sv
// Ping-pong loader for 32x32 current blocks: the last beat of a block lands at T, begin_prepare comes at T+2, and the 16 beats stream out at T+3..T+18.
// Backpressure: in_ready drops while the bank being written is still full, and it rises one cycle after search_done releases that bank.
module curr_block_loader (
    input  logic              clk,
    input  logic              rst_n,
    curr_block_loader_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_STREAM, ST_SEARCH} state_t;

    logic [511:0] mem_q [2][16];

    logic [3:0]   wr_cnt_q, wr_cnt_d;
    logic         wr_bank_q, wr_bank_d;
    logic [1:0]   bank_full_q, bank_full_d;

    state_t       state_q;
    logic         rd_bank_q;
    logic [3:0]   rd_cnt_q;
    logic         begin_prepare_q;
    logic         cur_valid_q;
    logic [511:0] cur_pix_q;

    logic         in_rdy;
    logic         wr_fire;
    logic         wr_last;
    logic         rd_release;

    // The port name says _n, but the reset is active-high. Ready is held low while reset is asserted.
    always_comb begin
        in_rdy     = !rst_n && !bank_full_q[wr_bank_q];
        wr_fire    = bus.in_valid && in_rdy;
        wr_last    = wr_fire && (wr_cnt_q == 4'd15);
        rd_release = (state_q == ST_SEARCH) && bus.search_done;
    end

    // A release of the read bank and the completion of the write bank can land in the same cycle.
    // They always touch different banks, so both updates apply.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        bank_full_d = bank_full_q;
        if (rd_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
        end
        if (wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = !wr_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_cnt_q    <= 4'd0;
            wr_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            bank_full_q <= bank_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= bus.in_data;
        end
    end

    // rd_cnt_q is the index of the beat currently shown in STREAM. The next beat is prefetched at each edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q         <= ST_IDLE;
            rd_bank_q       <= 1'b0;
            rd_cnt_q        <= 4'd0;
            begin_prepare_q <= 1'b0;
            cur_valid_q     <= 1'b0;
            cur_pix_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        state_q         <= ST_PREP;
                        begin_prepare_q <= 1'b1;
                    end
                end
                ST_PREP: begin
                    state_q         <= ST_STREAM;
                    begin_prepare_q <= 1'b0;
                    cur_valid_q     <= 1'b1;
                    cur_pix_q       <= mem_q[rd_bank_q][0];
                    rd_cnt_q        <= 4'd0;
                end
                ST_STREAM: begin
                    if (rd_cnt_q == 4'd15) begin
                        state_q     <= ST_SEARCH;
                        cur_valid_q <= 1'b0;
                    end else begin
                        cur_pix_q <= mem_q[rd_bank_q][rd_cnt_q + 4'd1];
                        rd_cnt_q  <= rd_cnt_q + 4'd1;
                    end
                end
                ST_SEARCH: begin
                    if (bus.search_done) begin
                        state_q   <= ST_IDLE;
                        rd_bank_q <= !rd_bank_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready         = in_rdy;
    assign bus.begin_prepare    = begin_prepare_q;
    assign bus.cur_valid        = cur_valid_q;
    assign bus.current_64pixels = cur_pix_q;
    assign bus.bank_full        = bank_full_q;
endmodule
